// File: rtl/rect_fill.sv
// Rectangle fill engine: sweeps a latched rectangle row-major onto a VGA pixel port.
// Define RECT_CLIP_EN to suppress plot for pixels outside SCREEN_W x SCREEN_H.
module rect_fill #(
  parameter int unsigned SCREEN_W = 160,
  parameter int unsigned SCREEN_H = 120
) (
  input  logic       CLOCK_50,
  input  logic       resetn,
  input  logic       start,
  input  logic       clear,
  input  logic [7:0] x0,
  input  logic [6:0] y0,
  input  logic [7:0] w,
  input  logic [6:0] h,
  input  logic [2:0] colour_in,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       vga_resetn,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {StIdle, StDraw, StDone} state_e;

`ifdef RECT_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif
  localparam logic [8:0] ScreenW = 9'(SCREEN_W);
  localparam logic [7:0] ScreenH = 8'(SCREEN_H);

  state_e     state_q, state_d;
  logic [7:0] x0_q, x0_d, w_q, w_d, col_q, col_d;
  logic [6:0] y0_q, y0_d, h_q, h_d, row_q, row_d;
  logic [2:0] fill_q, fill_d;
  logic [7:0] x_q, x_d;
  logic [6:0] y_q, y_d;
  logic [2:0] colour_q, colour_d;
  logic       plot_q, plot_d, busy_q, busy_d, done_q, done_d, vres_q, vres_d;

  // Next pixel to emit: the rectangle origin when leaving IDLE, else the next sweep step.
  logic       last_col, last_row;
  logic [7:0] col_nxt, px;
  logic [6:0] row_nxt, py;
  logic [2:0] pc;
  logic       pix_on;

  always_comb begin
    last_col = (col_q == w_q - 8'd1);
    last_row = (row_q == h_q - 7'd1);
    col_nxt  = last_col ? 8'd0 : col_q + 8'd1;
    row_nxt  = last_col ? row_q + 7'd1 : row_q;
    if (state_q == StIdle) begin
      px = x0;
      py = y0;
      pc = colour_in;
    end else begin
      px = x0_q + col_nxt;
      py = y0_q + row_nxt;
      pc = fill_q;
    end
    pix_on = !ClipEn || (({1'b0, px} < ScreenW) && ({1'b0, py} < ScreenH));
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    fill_d   = fill_q;
    col_d    = col_q;
    row_d    = row_q;
    x_d      = x_q;
    y_d      = y_q;
    colour_d = colour_q;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    vres_d   = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (clear) begin
          vres_d = 1'b0;
        end else if (start) begin
          x0_d   = x0;
          y0_d   = y0;
          w_d    = w;
          h_d    = h;
          fill_d = colour_in;
          col_d  = 8'd0;
          row_d  = 7'd0;
          if (w != 8'd0 && h != 7'd0) begin
            state_d = StDraw;
            busy_d  = 1'b1;
            if (pix_on) begin
              x_d      = px;
              y_d      = py;
              colour_d = pc;
              plot_d   = 1'b1;
            end
          end else begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
      end
      StDraw: begin
        if (last_col && last_row) begin
          state_d = StDone;
          done_d  = 1'b1;
        end else begin
          col_d  = col_nxt;
          row_d  = row_nxt;
          busy_d = 1'b1;
          if (pix_on) begin
            x_d      = px;
            y_d      = py;
            colour_d = pc;
            plot_d   = 1'b1;
          end
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      x0_q     <= '0;
      y0_q     <= '0;
      w_q      <= '0;
      h_q      <= '0;
      fill_q   <= '0;
      col_q    <= '0;
      row_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      vres_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      x0_q     <= x0_d;
      y0_q     <= y0_d;
      w_q      <= w_d;
      h_q      <= h_d;
      fill_q   <= fill_d;
      col_q    <= col_d;
      row_q    <= row_d;
      x_q      <= x_d;
      y_q      <= y_d;
      colour_q <= colour_d;
      plot_q   <= plot_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      vres_q   <= vres_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign colour     = colour_q;
  assign plot       = plot_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign vga_resetn = vres_q;

endmodule

// File: tb/tb_rect_fill.sv
// Self-checking bench for rect_fill: pixel-list reference model plus directed literal checks.
module tb_rect_fill;

  logic       CLOCK_50 = 1'b0;
  logic       resetn = 1'b0;
  logic       start = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] x0 = '0, w = '0;
  logic [6:0] y0 = '0, h = '0;
  logic [2:0] colour_in = '0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, vga_resetn, busy, done;

`ifdef RECT_CLIP_EN
  localparam bit ClipEn = 1'b1;
`else
  localparam bit ClipEn = 1'b0;
`endif

  rect_fill #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .CLOCK_50  (CLOCK_50),
    .resetn    (resetn),
    .start     (start),
    .clear     (clear),
    .x0        (x0),
    .y0        (y0),
    .w         (w),
    .h         (h),
    .colour_in (colour_in),
    .x         (x),
    .y         (y),
    .colour    (colour),
    .plot      (plot),
    .vga_resetn(vga_resetn),
    .busy      (busy),
    .done      (done)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a command expands into a list of per-cycle items, then a done item.
  typedef struct {
    logic       is_done;
    logic       on;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
  } item_t;

  item_t      mq[$];
  item_t      m_it;
  bit         m_was_done;
  logic [7:0] ex;
  logic [6:0] ey;
  logic [2:0] ec;
  logic       eplot, ebusy, edone, evres;

  function automatic bit on_screen(input logic [7:0] px, input logic [6:0] py);
    return !ClipEn || (int'(px) < 160 && int'(py) < 120);
  endfunction

  always @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      mq.delete();
      ex = '0; ey = '0; ec = '0;
      eplot = 0; ebusy = 0; edone = 0; evres = 1;
    end else begin
      m_was_done = edone;
      eplot = 0; ebusy = 0; edone = 0; evres = 1;
      if (mq.size() == 0 && !m_was_done) begin
        if (clear) begin
          evres = 0;
        end else if (start) begin
          for (int r = 0; r < int'(h); r++) begin
            for (int c = 0; c < int'(w); c++) begin
              m_it.is_done = 0;
              m_it.x  = 8'((int'(x0) + c) % 256);
              m_it.y  = 7'((int'(y0) + r) % 128);
              m_it.c  = colour_in;
              m_it.on = on_screen(m_it.x, m_it.y);
              mq.push_back(m_it);
            end
          end
          m_it = '{is_done: 1'b1, on: 1'b0, x: 8'd0, y: 7'd0, c: 3'd0};
          mq.push_back(m_it);
        end
      end
      if (mq.size() > 0) begin
        m_it = mq.pop_front();
        if (m_it.is_done) begin
          edone = 1;
        end else begin
          ebusy = 1;
          if (m_it.on) begin
            eplot = 1; ex = m_it.x; ey = m_it.y; ec = m_it.c;
          end
        end
      end
    end
  end

  logic [17:0] plog[$];
  int          busy_cnt = 0;
  int          done_cnt = 0;

  always @(negedge CLOCK_50) begin
    chk("plot", plot, eplot);
    chk("busy", busy, ebusy);
    chk("done", done, edone);
    chk("vga_resetn", vga_resetn, evres);
    chk("x", x, ex);
    chk("y", y, ey);
    chk("colour", colour, ec);
    if (plot) plog.push_back({x, y, colour});
    if (busy) busy_cnt++;
    if (done) done_cnt++;
  end

  task automatic tick();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic clr_log();
    plog.delete();
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic issue(input logic [7:0] ax, input logic [6:0] ay, input logic [7:0] aw,
                       input logic [6:0] ah, input logic [2:0] ac);
    x0 = ax; y0 = ay; w = aw; h = ah; colour_in = ac;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_done(input int limit);
    bit seen = 0;
    for (int i = 0; i < limit && !seen; i++) begin
      tick();
      if (done) seen = 1;
    end
    chk("wait_done", 32'(seen), 32'd1);
  endtask

  task automatic check_log(input string name, input logic [17:0] exp_q[$]);
    chk({name, "_len"}, plog.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < plog.size(); i++) chk(name, plog[i], exp_q[i]);
  endtask

  logic [17:0] eq[$];

  initial begin
    tick();
    tick();
    chk("rst_x", x, 0);
    chk("rst_plot", plot, 0);
    chk("rst_vres", vga_resetn, 1);
    resetn = 1;
    tick();

    // 3x2 fill at (10,5) colour 4
    clr_log();
    issue(8'd10, 7'd5, 8'd3, 7'd2, 3'd4);
    chk("first_pix_plot", plot, 1);
    chk("first_pix_x", x, 10);
    chk("first_pix_y", y, 5);
    wait_done(20);
    tick();
    eq = '{{8'd10, 7'd5, 3'd4}, {8'd11, 7'd5, 3'd4}, {8'd12, 7'd5, 3'd4},
           {8'd10, 7'd6, 3'd4}, {8'd11, 7'd6, 3'd4}, {8'd12, 7'd6, 3'd4}};
    check_log("rect34", eq);
    chk("rect34_busy", busy_cnt, 6);
    chk("rect34_done", done_cnt, 1);

    // zero width: straight to done
    clr_log();
    issue(8'd20, 7'd20, 8'd0, 7'd7, 3'd1);
    chk("w0_done", done, 1);
    chk("w0_busy", busy, 0);
    tick();
    chk("w0_done_gone", done, 0);
    chk("w0_plots", plog.size(), 0);
    chk("w0_busycnt", busy_cnt, 0);

    // clear wins over start
    clr_log();
    x0 = 8'd3; y0 = 7'd3; w = 8'd2; h = 7'd2;
    clear = 1; start = 1;
    tick();
    chk("clr_vres", vga_resetn, 0);
    chk("clr_plot", plot, 0);
    clear = 0; start = 0;
    tick();
    chk("clr_vres_back", vga_resetn, 1);
    chk("clr_done", done_cnt, 0);
    issue(8'd1, 7'd1, 8'd1, 7'd1, 3'd2);
    wait_done(10);
    tick();
    eq = '{{8'd1, 7'd1, 3'd2}};
    check_log("after_clr", eq);

    // restart during DRAW is ignored
    clr_log();
    issue(8'd30, 7'd40, 8'd2, 7'd2, 3'd3);
    x0 = 8'd50; start = 1;
    tick();
    start = 0;
    wait_done(10);
    tick();
    eq = '{{8'd30, 7'd40, 3'd3}, {8'd31, 7'd40, 3'd3}, {8'd30, 7'd41, 3'd3},
           {8'd31, 7'd41, 3'd3}};
    check_log("restart", eq);

    // reset mid-fill
    clr_log();
    issue(8'd0, 7'd0, 8'd4, 7'd4, 3'd5);
    tick();
    tick();
    chk("pre_rst_plots", plog.size(), 3);
    resetn = 0;
    #1;
    chk("mid_rst_plot", plot, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_x", x, 0);
    chk("mid_rst_colour", colour, 0);
    tick();
    resetn = 1;
    tick();
    chk("mid_rst_nodone", done_cnt, 0);
    clr_log();
    issue(8'd2, 7'd3, 8'd2, 7'd1, 3'd6);
    wait_done(10);
    tick();
    eq = '{{8'd2, 7'd3, 3'd6}, {8'd3, 7'd3, 3'd6}};
    check_log("post_rst", eq);

    // right-edge rectangle
    clr_log();
    issue(8'd158, 7'd0, 8'd4, 7'd1, 3'd7);
    wait_done(10);
    tick();
    if (ClipEn) eq = '{{8'd158, 7'd0, 3'd7}, {8'd159, 7'd0, 3'd7}};
    else eq = '{{8'd158, 7'd0, 3'd7}, {8'd159, 7'd0, 3'd7}, {8'd160, 7'd0, 3'd7},
                {8'd161, 7'd0, 3'd7}};
    check_log("edge", eq);
    chk("edge_busy", busy_cnt, 4);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      x0 = 8'($urandom_range(0, 255));
      y0 = 7'($urandom_range(0, 127));
      w = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
      h = 7'($urandom_range(0, 4));
      colour_in = 3'($urandom_range(0, 7));
      start = ($urandom_range(0, 3) == 0);
      clear = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 399) == 0) begin
        resetn = 0;
        #1;
        resetn = 1;
      end
      tick();
    end
    start = 0;
    clear = 0;
    repeat (300) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
